arq_link_tx_scheduler: RTL

//  Shares one physical TX link between the local ARQ sender's payload beats and the cumulative

---
 rtl/arq_link_tx_scheduler_pkg.sv | 21 ++
 rtl/arq_link_tx_scheduler_ack_slot.sv | 85 ++++++++
 rtl/arq_link_tx_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/arq_link_tx_scheduler_pkg.sv
// Shared types for the ARQ link TX scheduler: link beat kind, beat layout, default widths.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package arq_link_tx_scheduler_pkg;

  localparam int SEQ_W_DEF  = 8;
  localparam int DATA_W_DEF = 32;
  localparam int STAT_W     = 16;

  typedef enum logic {
    LINK_DATA = 1'b0,
    LINK_ACK  = 1'b1
  } link_kind_e;

  typedef struct packed {
    link_kind_e                  kind;
    logic [SEQ_W_DEF-1:0]        seq;
    logic [DATA_W_DEF-1:0]       p;
  } link_beat_t;

endpackage

// File: rtl/arq_link_tx_scheduler_ack_slot.sv
// Single-entry pending-ack slot with defer timer and merge statistics.
// Latency: accepted ack is visible as pending on the cycle after acceptance.
// Backpressure: ack_ready=1 with ARQ_ACK_COALESCE_EN (overwrite), else only when slot empties/frees.
module arq_link_tx_scheduler_ack_slot
  import arq_link_tx_scheduler_pkg::*;
#(
  parameter int SEQ_W         = SEQ_W_DEF,
  parameter int ACK_MAX_DEFER = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ack_valid,
  input  logic [SEQ_W-1:0]  i_ack_seq,
  input  logic              i_ack_grant,
  output logic              o_ack_ready,
  output logic              o_pend,
  output logic [SEQ_W-1:0]  o_seq,
  output logic              o_defer_sat,
  output logic [STAT_W-1:0] o_stat
);

  localparam int DEFER_W = $clog2(ACK_MAX_DEFER + 1);

  logic               r_pend;
  logic [SEQ_W-1:0]   r_seq;
  logic [DEFER_W-1:0] r_defer;
  logic               w_ready_raw;
  logic               w_accept;

`ifdef ARQ_ACK_COALESCE_EN
  // Slot always takes a new ack; the newest number replaces the pending one.
  assign w_ready_raw = 1'b1;
`else
  // Slot takes a new ack only when empty or being drained this cycle.
  assign w_ready_raw = !r_pend || i_ack_grant;
`endif

  assign o_ack_ready = w_ready_raw && !i_rst;
  assign w_accept    = i_ack_valid && o_ack_ready;
  assign o_pend      = r_pend;
  assign o_seq       = r_seq;
  assign o_defer_sat = (r_defer == DEFER_W'(ACK_MAX_DEFER));

  // Pending flag and ack number; a new ack wins over a same-cycle drain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend <= 1'b0;
      r_seq  <= '0;
    end else if (w_accept) begin
      r_pend <= 1'b1;
      r_seq  <= i_ack_seq;
    end else if (i_ack_grant) begin
      r_pend <= 1'b0;
    end
  end

  // Defer timer: age of the pending ack, counting stalls; overwrites do not restart it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_defer <= '0;
    end else if (i_ack_grant) begin
      r_defer <= '0;
    end else if (r_pend && !o_defer_sat) begin
      r_defer <= r_defer + DEFER_W'(1);
    end
  end

`ifdef ARQ_ACK_COALESCE_EN
  logic [STAT_W-1:0] r_stat;

  // Saturating count of pending acks replaced before reaching the link.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat <= '0;
    end else if (w_accept && r_pend && !i_ack_grant && (r_stat != {STAT_W{1'b1}})) begin
      r_stat <= r_stat + STAT_W'(1);
    end
  end

  assign o_stat = r_stat;
`else
  assign o_stat = '0;
`endif

endmodule

// File: rtl/arq_link_tx_scheduler.sv
// Merges ARQ payload beats and cumulative acks onto one registered TX link stream.
// Latency: data 1 cycle, ack >= 2 cycles (through the pending slot).
// Backpressure: grants only when the output register is free; holds link_* while stalled.
// Optional feature macro: ARQ_ACK_COALESCE_EN (ack coalescing in the pending slot).
module arq_link_tx_scheduler
  import arq_link_tx_scheduler_pkg::*;
#(
  parameter int SEQ_W         = SEQ_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int DATA_BURST    = 4,
  parameter int ACK_MAX_DEFER = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  input  logic [SEQ_W-1:0]  i_data_seq,
  input  logic [DATA_W-1:0] i_data_p,
  input  logic              i_ack_valid,
  output logic              o_ack_ready,
  input  logic [SEQ_W-1:0]  i_ack_seq,
  output logic              o_link_valid,
  input  logic              i_link_ready,
  output logic              o_link_kind,
  output logic [SEQ_W-1:0]  o_link_seq,
  output logic [DATA_W-1:0] o_link_p,
  output logic [15:0]       o_stat_acks_merged
);

  localparam int BURST_W = $clog2(DATA_BURST + 1);

  logic               r_link_valid;
  link_kind_e         r_link_kind;
  logic [SEQ_W-1:0]   r_link_seq;
  logic [DATA_W-1:0]  r_link_p;
  logic [BURST_W-1:0] r_burst;

  logic               w_free;
  logic               w_pend;
  logic [SEQ_W-1:0]   w_pend_seq;
  logic               w_defer_sat;
  logic               w_burst_full;
  logic               w_grant_ack;
  logic               w_grant_data;

  arq_link_tx_scheduler_ack_slot #(
    .SEQ_W         (SEQ_W),
    .ACK_MAX_DEFER (ACK_MAX_DEFER)
  ) u_ack_slot (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ack_valid (i_ack_valid),
    .i_ack_seq   (i_ack_seq),
    .i_ack_grant (w_grant_ack),
    .o_ack_ready (o_ack_ready),
    .o_pend      (w_pend),
    .o_seq       (w_pend_seq),
    .o_defer_sat (w_defer_sat),
    .o_stat      (o_stat_acks_merged)
  );

  // Arbitration: a pending ack wins when data is idle, the burst is used up, or it has waited too long.
  assign w_free       = !r_link_valid || i_link_ready;
  assign w_burst_full = (r_burst == BURST_W'(DATA_BURST));
  assign w_grant_ack  = w_free && w_pend && (!i_data_valid || w_burst_full || w_defer_sat);
  assign w_grant_data = w_free && !w_grant_ack && i_data_valid;
  assign o_data_ready = w_grant_data && !i_rst;

  // Burst counter: consecutive data grants taken while an ack waits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_burst <= '0;
    end else if (w_grant_ack || !w_pend) begin
      r_burst <= '0;
    end else if (w_grant_data && !w_burst_full) begin
      r_burst <= r_burst + BURST_W'(1);
    end
  end

  // Output register: loads the winning beat when free, otherwise holds the stalled beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_link_valid <= 1'b0;
      r_link_kind  <= LINK_DATA;
      r_link_seq   <= '0;
      r_link_p     <= '0;
    end else if (w_free) begin
      if (w_grant_ack) begin
        r_link_valid <= 1'b1;
        r_link_kind  <= LINK_ACK;
        r_link_seq   <= w_pend_seq;
        r_link_p     <= '0;
      end else if (w_grant_data) begin
        r_link_valid <= 1'b1;
        r_link_kind  <= LINK_DATA;
        r_link_seq   <= i_data_seq;
        r_link_p     <= i_data_p;
      end else begin
        r_link_valid <= 1'b0;
      end
    end
  end

  assign o_link_valid = r_link_valid;
  assign o_link_kind  = r_link_kind;
  assign o_link_seq   = r_link_seq;
  assign o_link_p     = r_link_p;

endmodule
